// File: rtl/writeback_unit.sv
// Final pipeline stage: retires register writes and waits, with a timeout, for load data on a stall handshake.
// Optional build macro RF_BYPASS_EN forwards the write in progress to the read ports.
module writeback_unit #(
    parameter int DATA_SIZE      = 32,
    parameter int GPR_SIZE       = 3,
    parameter int OP_WB_SIZE     = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_SIZE-1:0]  result,
    input  logic [GPR_SIZE-1:0]   destination,
    input  logic [OP_WB_SIZE-1:0] writeback,
    input  logic [DATA_SIZE-1:0]  data_in,
    input  logic                  data_valid,
    input  logic [GPR_SIZE-1:0]   rd_sel0,
    input  logic [GPR_SIZE-1:0]   rd_sel1,
    input  logic [GPR_SIZE-1:0]   rd_sel2,
    output logic [DATA_SIZE-1:0]  rd_data0,
    output logic [DATA_SIZE-1:0]  rd_data1,
    output logic [DATA_SIZE-1:0]  rd_data2,
    output logic                  stall,
    output logic                  load_error,
    output logic [15:0]           retired
);

    localparam logic [OP_WB_SIZE-1:0] WB_NONE     = OP_WB_SIZE'(0);
    localparam logic [OP_WB_SIZE-1:0] WB_REGISTER = OP_WB_SIZE'(1);
    localparam logic [OP_WB_SIZE-1:0] WB_MEMORY   = OP_WB_SIZE'(2);
    localparam int                    NUM_REGS    = 1 << GPR_SIZE;
    localparam logic [7:0]            LAST_WAIT   = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    state_t                state, state_next;
    logic [GPR_SIZE-1:0]   pending_dest, pending_dest_next;
    logic [7:0]            wait_count, wait_count_next;
    logic                  load_error_next;
    logic                  wr_en;
    logic [GPR_SIZE-1:0]   wr_idx;
    logic [DATA_SIZE-1:0]  wr_data;
    logic [DATA_SIZE-1:0]  rf [NUM_REGS];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next        = state;
        pending_dest_next = pending_dest;
        wait_count_next   = wait_count;
        load_error_next   = load_error;
        wr_en             = 1'b0;
        wr_idx            = destination;
        wr_data           = result;

        unique case (state)
            IDLE: begin
                unique case (writeback)
                    WB_REGISTER: wr_en = 1'b1;
                    WB_MEMORY: begin
                        if (data_valid) begin
                            wr_en   = 1'b1;
                            wr_data = data_in;
                        end else begin
                            pending_dest_next = destination;
                            wait_count_next   = 8'd0;
                            state_next        = WAIT_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
            WAIT_LOAD: begin
                // The held instruction is not looked at until the load resolves.
                wr_idx  = pending_dest;
                wr_data = data_in;
                if (data_valid) begin
                    wr_en      = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_count_next = wait_count + 8'd1;
                    if (wait_count == LAST_WAIT) begin
                        load_error_next = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pending_dest <= '0;
            wait_count   <= 8'd0;
            load_error   <= 1'b0;
            retired      <= 16'd0;
        end else begin
            state        <= state_next;
            pending_dest <= pending_dest_next;
            wait_count   <= wait_count_next;
            load_error   <= load_error_next;
            if (wr_en) begin
                retired <= retired + 16'd1;
            end
        end
    end

    // NOTE: the register file is reset on purpose: read ports must return 0 straight out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[wr_idx] <= wr_data;
        end
    end

    assign stall = (state == WAIT_LOAD);

`ifdef RF_BYPASS_EN
    assign rd_data0 = (wr_en && wr_idx == rd_sel0) ? wr_data : rf[rd_sel0];
    assign rd_data1 = (wr_en && wr_idx == rd_sel1) ? wr_data : rf[rd_sel1];
    assign rd_data2 = (wr_en && wr_idx == rd_sel2) ? wr_data : rf[rd_sel2];
`else
    assign rd_data0 = rf[rd_sel0];
    assign rd_data1 = rf[rd_sel1];
    assign rd_data2 = rf[rd_sel2];
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed load/timeout/reset scenarios followed by randomized traffic,
// all compared against a transaction-level model of the register file and load wait.
module tb_writeback_unit;

    localparam int DATA_SIZE  = 32;
    localparam int GPR_SIZE   = 3;
    localparam int OP_WB_SIZE = 2;
    localparam int TIMEOUT    = 4;
    localparam int NREG       = 8;
    localparam logic [1:0] WB_NONE     = 2'd0;
    localparam logic [1:0] WB_REGISTER = 2'd1;
    localparam logic [1:0] WB_MEMORY   = 2'd2;

    logic        clock;
    logic        reset;
    logic [31:0] result;
    logic [2:0]  destination;
    logic [1:0]  writeback;
    logic [31:0] data_in;
    logic        data_valid;
    logic [2:0]  rd_sel0, rd_sel1, rd_sel2;
    logic [31:0] rd_data0, rd_data1, rd_data2;
    logic        stall;
    logic        load_error;
    logic [15:0] retired;

    writeback_unit #(
        .DATA_SIZE      (DATA_SIZE),
        .GPR_SIZE       (GPR_SIZE),
        .OP_WB_SIZE     (OP_WB_SIZE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .result      (result),
        .destination (destination),
        .writeback   (writeback),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .rd_sel0     (rd_sel0),
        .rd_sel1     (rd_sel1),
        .rd_sel2     (rd_sel2),
        .rd_data0    (rd_data0),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .stall       (stall),
        .load_error  (load_error),
        .retired     (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int stall_seen = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference model: a register array plus "is a load outstanding, for whom, for how long".
    logic [31:0] m_rf [NREG];
    bit          m_waiting;
    logic [2:0]  m_pend;
    int          m_waited;
    bit          m_err;
    logic [15:0] m_retired;

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = 32'd0;
        m_waiting = 0;
        m_pend    = 3'd0;
        m_waited  = 0;
        m_err     = 0;
        m_retired = 16'd0;
    endfunction

    // Which register (if any) the current cycle writes, given the model state and present inputs.
    function automatic void model_intent(output bit we, output logic [2:0] idx, output logic [31:0] data);
        we   = 0;
        idx  = destination;
        data = result;
        if (m_waiting) begin
            we   = data_valid;
            idx  = m_pend;
            data = data_in;
        end else if (writeback == WB_REGISTER) begin
            we = 1;
        end else if (writeback == WB_MEMORY) begin
            we   = data_valid;
            data = data_in;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] sel);
        bit          we;
        logic [2:0]  idx;
        logic [31:0] data;
        model_intent(we, idx, data);
`ifdef RF_BYPASS_EN
        if (we && idx == sel) return data;
`endif
        return m_rf[sel];
    endfunction

    function automatic void model_step();
        bit          we;
        logic [2:0]  idx;
        logic [31:0] data;
        model_intent(we, idx, data);
        if (we) begin
            m_rf[idx] = data;
            m_retired = m_retired + 16'd1;
        end
        if (m_waiting) begin
            m_waited++;
            if (data_valid) m_waiting = 0;
            else if (m_waited == TIMEOUT) begin
                m_err     = 1;
                m_waiting = 0;
            end
        end else if (writeback == WB_MEMORY && !data_valid) begin
            m_waiting = 1;
            m_pend    = destination;
            m_waited  = 0;
        end
    endfunction

    task automatic compare_all();
        check("rd_data0",   rd_data0,   model_read(rd_sel0));
        check("rd_data1",   rd_data1,   model_read(rd_sel1));
        check("rd_data2",   rd_data2,   model_read(rd_sel2));
        check("stall",      stall,      m_waiting);
        check("load_error", load_error, m_err);
        check("retired",    retired,    m_retired);
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 time unit later, then the model advances.
    task automatic cycle();
        #1;
        compare_all();
        if (stall) stall_seen++;
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic issue(input logic [1:0] wb, input logic [2:0] dst, input logic [31:0] res);
        writeback   = wb;
        destination = dst;
        result      = res;
    endtask

    initial begin
        reset = 1'b0;
        issue(WB_NONE, 3'd0, 32'd0);
        data_in    = 32'd0;
        data_valid = 1'b0;
        rd_sel0    = 3'd0;
        rd_sel1    = 3'd3;
        rd_sel2    = 3'd7;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        #1;
        check("reset_rd0", rd_data0, 32'd0);
        check("reset_rd3", rd_data1, 32'd0);
        check("reset_rd7", rd_data2, 32'd0);
        check("reset_stall", stall, 1'b0);
        check("reset_retired", retired, 16'd0);
        check("reset_load_error", load_error, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // Plain register write.
        rd_sel0 = 3'd5;
        issue(WB_REGISTER, 3'd5, 32'hDEADBEEF);
        cycle();
        issue(WB_NONE, 3'd0, 32'd0);
        #1;
        check("reg_write_r5", rd_data0, 32'hDEADBEEF);
        check("reg_write_retired", retired, 16'd1);

        // Load with data 3 cycles after entry, next instruction held behind it.
        stall_seen = 0;
        issue(WB_MEMORY, 3'd2, 32'd0);
        cycle();
        issue(WB_REGISTER, 3'd6, 32'h0000_0055);
        for (int i = 1; i <= 3; i++) begin
            data_valid = (i == 3);
            data_in    = (i == 3) ? 32'h1234 : 32'hFFFF_FFFF;
            cycle();
        end
        data_valid = 1'b0;
        rd_sel1 = 3'd2;
        #1;
        check("load_r2", rd_data1, 32'h1234);
        check("load_retired", retired, 16'd2);
        check("held_not_stalled", stall, 1'b0);
        cycle();
        issue(WB_NONE, 3'd0, 32'd0);
        rd_sel2 = 3'd6;
        #1;
        check("held_write_r6", rd_data2, 32'h55);
        check("held_retired", retired, 16'd3);
        check("load_stall_cycles", stall_seen, 3);

        // Data arriving on the timeout cycle wins.
        issue(WB_MEMORY, 3'd3, 32'd0);
        cycle();
        issue(WB_NONE, 3'd0, 32'd0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            data_valid = (i == TIMEOUT);
            data_in    = 32'hA5;
            cycle();
        end
        data_valid = 1'b0;
        rd_sel0 = 3'd3;
        #1;
        check("coincident_r3", rd_data0, 32'hA5);
        check("coincident_load_error", load_error, 1'b0);

        // Timeout: no write, error sticks.
        stall_seen = 0;
        rd_sel0 = 3'd1;
        issue(WB_MEMORY, 3'd1, 32'd0);
        cycle();
        issue(WB_NONE, 3'd0, 32'd0);
        data_in = 32'hBAD0_BAD0;
        repeat (TIMEOUT + 1) cycle();
        #1;
        check("timeout_stall_cycles", stall_seen, TIMEOUT);
        check("timeout_load_error", load_error, 1'b1);
        check("timeout_r1_unchanged", rd_data0, 32'd0);
        check("timeout_retired", retired, 16'd4);

        // Normal load afterward leaves the error set.
        issue(WB_MEMORY, 3'd1, 32'd0);
        cycle();
        issue(WB_NONE, 3'd0, 32'd0);
        data_valid = 1'b1;
        data_in    = 32'h0BAD_F00D;
        cycle();
        data_valid = 1'b0;
        #1;
        check("second_load_r1", rd_data0, 32'h0BAD_F00D);
        check("error_sticky", load_error, 1'b1);

        // Reset in the middle of a load wait.
        issue(WB_MEMORY, 3'd4, 32'd0);
        cycle();
        issue(WB_NONE, 3'd0, 32'd0);
        cycle();
        reset = 1'b0;
        #1;
        check("midreset_stall", stall, 1'b0);
        check("midreset_load_error", load_error, 1'b0);
        check("midreset_rd_r1", rd_data0, 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 32'h77;
        cycle();
        data_valid = 1'b0;
        for (int b = 0; b < NREG; b += 3) begin
            rd_sel0 = 3'(b);
            rd_sel1 = 3'((b + 1) % NREG);
            rd_sel2 = 3'((b + 2) % NREG);
            #1;
            check("post_reset_rd0", rd_data0, 32'd0);
            check("post_reset_rd1", rd_data1, 32'd0);
            check("post_reset_rd2", rd_data2, 32'd0);
            cycle();
        end
        check("post_reset_retired", retired, 16'd0);

        // Randomized traffic; the instruction only changes while the unit is not stalling.
        for (int n = 0; n < 600; n++) begin
            if (!m_waiting) begin
                issue(2'($urandom_range(0, 2)), 3'($urandom_range(0, NREG - 1)), $urandom);
            end
            data_valid = ($urandom_range(0, 9) < 3);
            data_in    = $urandom;
            rd_sel0    = 3'($urandom_range(0, NREG - 1));
            rd_sel1    = 3'($urandom_range(0, NREG - 1));
            rd_sel2    = 3'($urandom_range(0, NREG - 1));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Fourth and final pipeline stage, directly downstream of the execute stage. Consumes the registered `result`, `destination` and `writeback` triple and owns the general-purpose register file (`1 << GPR_SIZE` entries of `DATA_SIZE` bits). Register writes retire immediately; loads wait for data memory through a stall handshake with a timeout. Three combinational read ports serve the operand-fetch stage.

## Interface
- `TIMEOUT_CYCLES`, default 15: number of WAIT_LOAD cycles without `data_valid` before a load is abandoned; legal range 1..255.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `result`  in  `DATA_SIZE`  value to write for `WB_REGISTER`.
- `destination`  in  `GPR_SIZE`  target register index.
- `writeback`  in  `OP_WB_SIZE`  `WB_NONE` / `WB_REGISTER` / `WB_MEMORY`.
- `data_in`  in  `DATA_SIZE`  load data from data memory.
- `data_valid`  in  1  `data_in` valid this cycle.
- `rd_sel0`, `rd_sel1`, `rd_sel2`  in  `GPR_SIZE` each  read-port indices.
- `rd_data0`, `rd_data1`, `rd_data2`  out  `DATA_SIZE` each  combinational read data.
- `stall`  out  1  upstream must hold its stage registers while high.
- `load_error`  out  1  sticky; set on a load timeout.
- `retired`  out  16  count of completed register-file writes.

## Operation
- State machine with two states, IDLE and WAIT_LOAD. Reset enters IDLE.
- IDLE with `WB_NONE`: no write.
- IDLE with `WB_REGISTER`: `rf[destination] <= result` at the clock edge.
- IDLE with `WB_MEMORY` and `data_valid`=1: `rf[destination] <= data_in`; stay in IDLE.
- IDLE with `WB_MEMORY` and `data_valid`=0:
  - latch `destination` into `pending_dest`;
  - clear the timeout counter;
  - go to WAIT_LOAD.
- WAIT_LOAD: the `result`/`destination`/`writeback` inputs are ignored. They hold the next instruction, which upstream keeps stable.
  - `data_valid`=1: `rf[pending_dest] <= data_in`; go to IDLE.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`, set `load_error`, perform no write, and go to IDLE.
- `data_valid` in IDLE without `WB_MEMORY` is ignored.
- `retired` increments, wrapping from 0xFFFF to 0, on every register-file write. A timeout does not increment it.
- The unit never writes two registers in one cycle. Writes to any index, including 0, are allowed.
- `load_error` clears only on reset.

## Timing
- `stall` is registered: high exactly while in WAIT_LOAD. In the cycle `data_valid` ends the wait, `stall` is still high; it drops the following cycle.
- After a load wait completes, the held instruction is processed in the first IDLE cycle.
- Register-write latency is 1 cycle; the new value is visible on read ports the cycle after the edge.
- Load with `data_valid` on entry costs 0 stall cycles.
- Load with `data_valid` N cycles later (N ≥ 1, N < `TIMEOUT_CYCLES`) costs N stall cycles, counting the cycle `data_valid` arrives.
- Timeout costs `TIMEOUT_CYCLES` stall cycles.
- `data_valid` arriving in the same cycle the counter reaches `TIMEOUT_CYCLES`: the data wins. The write happens and `load_error` stays clear.
- Reset values: every `rf` entry 0, state IDLE, `stall` 0, `load_error` 0, `retired` 0, `pending_dest` 0, counter 0. Read ports therefore return 0.
- Reset asserted mid-WAIT_LOAD aborts the load with no write, and all state returns to reset values immediately.

## Configuration
- `RF_BYPASS_EN` defined: a read port whose index equals the index being written this cycle returns the write data (`result` or `data_in`) combinationally.
- `RF_BYPASS_EN` undefined: read ports return the stored value only; same-cycle writes become visible one cycle later.

## Test plan
- Reset, then read all ports with indices 0,3,7 -> `rd_data*`=0, `stall`=0, `retired`=0, `load_error`=0.
- `WB_REGISTER`, `destination`=5, `result`=0xDEADBEEF, with `rd_sel0`=5 held -> `rd_data0` shows 0xDEADBEEF the next cycle (same cycle with `RF_BYPASS_EN`); `retired`=1.
- `WB_MEMORY`, `destination`=2, `data_valid` raised 3 cycles after entry with `data_in`=0x1234 -> `stall` high 3 cycles, then r2=0x1234, `retired` increments once, next held `WB_REGISTER` instruction writes in the following cycle.
- `WB_MEMORY`, `data_valid` never, `TIMEOUT_CYCLES`=4 -> `stall` high 4 cycles, `load_error`=1, register file unchanged, `retired` unchanged; second load completing normally leaves `load_error`=1.
- `data_valid` coincident with the timeout cycle, `data_in`=0xA5 -> r[pending_dest]=0xA5, `load_error`=0.
- Reset pulsed during WAIT_LOAD, `data_valid` applied afterward -> no write, `stall`=0 immediately, all registers 0.
